mips_mc_controller: RTL
=======================

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning max cycles to wait for mem_ready (0 = no timeout).
REQ-002 SHALL have parameter ADD_OP, default 6'b001001, meaning the ALU op code used for PC and address adds.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port instr, input, 32 bits: instruction register contents.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory read data valid or write accepted.
REQ-007 SHALL have port resume, input, 1 bit: leave HALT.
REQ-008 SHALL have outputs pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, is_signed, alu_src_a, reg_write, reg_dst, mem_to_reg and jump_and_link, each 1 bit.
REQ-009 SHALL have outputs pc_source and alu_src_b, each 2 bits.
REQ-010 SHALL have output alu_op, 6 bits.
REQ-011 SHALL have outputs halted and illegal_op, each 1 bit.
REQ-012 SHALL have outputs mem_timeout_err, 1 bit, and cycle_count and instr_count, each 32 bits.

Function
REQ-013 States SHALL be: INIT, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, LOAD_MEM, LOAD_WB, STORE_MEM, BRANCH, JUMP, HALT.
REQ-014 Control outputs SHALL decode combinationally from the state register, instr and mem_ready; every unlisted output is 0.
REQ-015 INIT SHALL go to FETCH unconditionally.
REQ-016 FETCH SHALL drive mem_read=1, iord=0, alu_src_b=01, alu_op=ADD_OP, hold until mem_ready=1, then drive ir_write=1 and pc_write=1 in that cycle and go to DECODE.
REQ-017 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=ADD_OP, then branch on instr[31:26]:
- 000000 -> EXEC_R
- 000010 or 000011 -> JUMP
- 000100 or 000101 -> BRANCH
- 001001, 001010, 001100, 001101, 001110 or 010000 -> EXEC_I
- 100011 -> MEM_ADDR (load)
- 101011 -> MEM_ADDR (store)
- 111111 -> HALT
- any other opcode -> set sticky illegal_op and go to HALT.
REQ-018 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=instr[31:26], then go to WB_R.
REQ-019 WB_R SHALL hold the EXEC_R ALU controls and drive reg_dst=1, reg_write=1; if instr[5:0]=001000 (jr) it SHALL instead drive reg_write=0, pc_write=1, pc_source=11; it then goes to FETCH.
REQ-020 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10, alu_op=instr[31:26], and is_signed=1 for opcodes 001001 and 001010.
REQ-021 WB_I SHALL hold the EXEC_I controls plus reg_dst=0, reg_write=1, then go to FETCH.
REQ-022 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=ADD_OP, is_signed=1, then go to LOAD_MEM or STORE_MEM.
REQ-023 LOAD_MEM SHALL drive mem_read=1, iord=1, hold until mem_ready, then go to LOAD_WB.
REQ-024 LOAD_WB SHALL drive reg_dst=0, mem_to_reg=1, reg_write=1, then go to FETCH.
REQ-025 STORE_MEM SHALL drive mem_write=1, iord=1, hold until mem_ready, then go to FETCH.
REQ-026 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=instr[31:26], pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-027 JUMP SHALL drive pc_write=1 and pc_source=10, drive jump_and_link=1 only when instr[31:26]=000011, then go to FETCH.
REQ-028 HALT SHALL drive halted=1 and go to FETCH when resume=1.
REQ-029 A wait counter SHALL count cycles spent in FETCH, LOAD_MEM or STORE_MEM with mem_ready=0, and clear on state exit.
REQ-030 When MEM_TIMEOUT>0 and the wait counter reaches MEM_TIMEOUT, the block SHALL set sticky mem_timeout_err and go to HALT.
REQ-031 mem_ready arriving in the same cycle as the timeout SHALL win: normal transition, no error.
REQ-032 resume SHALL clear illegal_op and mem_timeout_err.

Reset
REQ-033 rst=1 SHALL force state INIT, clear the wait counter, illegal_op, mem_timeout_err and both count registers, and force every output to 0.
REQ-034 A rst asserted mid-wait SHALL abort the transfer with no write strobe in the following cycle.

Configuration
REQ-035 Macro MIPS_CTRL_PERF_EN defined: cycle_count SHALL increment every non-reset cycle, and instr_count SHALL increment on each FETCH->DECODE transition; both wrap at 2^32.
REQ-036 Macro MIPS_CTRL_PERF_EN undefined: cycle_count and instr_count SHALL be constant 0 with no counter logic.

Verification
REQ-037 Reset, then R-type add with mem_ready=1 -> FETCH, DECODE, EXEC_R, WB_R with reg_write=1 and reg_dst=1 only in WB_R; back in FETCH at cycle 5.
REQ-038 lw with mem_ready delayed 3 cycles in LOAD_MEM -> mem_read and iord held 4 cycles; LOAD_WB gives mem_to_reg=1, reg_write=1.
REQ-039 Opcode 6'b111100 -> illegal_op=1, halted=1; resume=1 -> FETCH, illegal_op=0.
REQ-040 MEM_TIMEOUT=4 with mem_ready=0 in FETCH -> mem_timeout_err=1 after 4 wait cycles, then HALT.
REQ-041 jal -> one JUMP cycle with pc_write=1, pc_source=10, jump_and_link=1; j -> same with jump_and_link=0.
REQ-042 PERF_EN defined, 10 single-cycle-memory addi instructions -> instr_count=10, cycle_count=41 (INIT + 4/instr).

Source files
------------

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with memory-wait timeout, halt/resume and sticky error flags.
// Define MIPS_CTRL_PERF_EN to build the cycle_count/instr_count performance counters.
module mips_mc_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [5:0]  ADD_OP      = 6'b001001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        resume,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        is_signed,
    output logic        alu_src_a,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        jump_and_link,
    output logic [1:0]  pc_source,
    output logic [1:0]  alu_src_b,
    output logic [5:0]  alu_op,
    output logic        halted,
    output logic        illegal_op,
    output logic        mem_timeout_err,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        INIT, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
        LOAD_MEM, LOAD_WB, STORE_MEM, BRANCH, JUMP, HALT
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic [5:0]        opcode;
    logic              waiting;
    logic              timeoutHit;
    logic              opIllegal;
    logic              unusedBits;

    assign opcode     = instr[31:26];
    assign unusedBits = ^instr[25:6];
    assign waiting    = ((state == FETCH) || (state == LOAD_MEM) || (state == STORE_MEM)) && !mem_ready;
    // A ready strobe in the would-be timeout cycle keeps waiting low, so it wins.
    assign timeoutHit = waiting && (MEM_TIMEOUT != 0) && (waitCnt == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state decode.
    always_comb begin
        nextState = state;
        opIllegal = 1'b0;
        case (state)
            INIT:      nextState = FETCH;
            FETCH:     if (mem_ready) nextState = DECODE;
            DECODE: begin
                case (opcode)
                    6'b000000:                         nextState = EXEC_R;
                    6'b000010, 6'b000011:              nextState = JUMP;
                    6'b000100, 6'b000101:              nextState = BRANCH;
                    6'b001001, 6'b001010, 6'b001100,
                    6'b001101, 6'b001110, 6'b010000:   nextState = EXEC_I;
                    6'b100011, 6'b101011:              nextState = MEM_ADDR;
                    6'b111111:                         nextState = HALT;
                    default: begin
                        opIllegal = 1'b1;
                        nextState = HALT;
                    end
                endcase
            end
            EXEC_R:    nextState = WB_R;
            WB_R:      nextState = FETCH;
            EXEC_I:    nextState = WB_I;
            WB_I:      nextState = FETCH;
            MEM_ADDR:  nextState = (opcode == 6'b101011) ? STORE_MEM : LOAD_MEM;
            LOAD_MEM:  if (mem_ready) nextState = LOAD_WB;
            LOAD_WB:   nextState = FETCH;
            STORE_MEM: if (mem_ready) nextState = FETCH;
            BRANCH:    nextState = FETCH;
            JUMP:      nextState = FETCH;
            HALT:      if (resume) nextState = FETCH;
            default:   nextState = INIT;
        endcase
        if (timeoutHit) nextState = HALT;
    end

    // Control decode; reset masks every strobe, including a pending write.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        is_signed     = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        jump_and_link = 1'b0;
        pc_source     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 6'b000000;
        halted        = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ADD_OP;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = ADD_OP;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = opcode;
                end
                WB_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = opcode;
                    reg_dst   = 1'b1;
                    if (instr[5:0] == 6'b001000) begin
                        pc_write  = 1'b1;
                        pc_source = 2'b11;
                    end else begin
                        reg_write = 1'b1;
                    end
                end
                EXEC_I, WB_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = opcode;
                    is_signed = (opcode == 6'b001001) || (opcode == 6'b001010);
                    reg_write = (state == WB_I);
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ADD_OP;
                    is_signed = 1'b1;
                end
                LOAD_MEM: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                LOAD_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                STORE_MEM: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = opcode;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write      = 1'b1;
                    pc_source     = 2'b10;
                    jump_and_link = (opcode == 6'b000011);
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    // State, wait counter and sticky error flags; a fresh error beats a same-cycle resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= INIT;
            waitCnt         <= '0;
            illegal_op      <= 1'b0;
            mem_timeout_err <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= (waiting && !timeoutHit) ? waitCnt + WAIT_W'(1) : '0;
            if (opIllegal)
                illegal_op <= 1'b1;
            else if (resume)
                illegal_op <= 1'b0;
            if (timeoutHit)
                mem_timeout_err <= 1'b1;
            else if (resume)
                mem_timeout_err <= 1'b0;
        end
    end

`ifdef MIPS_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if ((state == FETCH) && mem_ready)
                instr_count <= instr_count + 32'd1;
        end
    end
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule
